ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_pkg.sv | 19 +
 rtl/ws2812_edge_sync.sv | 27 ++
 rtl/ws2812_rx.sv | 194 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM state encoding, default timing constants at
// 50 MHz and the pixel width, common to the receiver and the transmitter.
package ws2812_pkg;

  localparam int PIXEL_W        = 24;
  localparam int DEF_BIT_THRESH = 30;
  localparam int DEF_MIN_HIGH   = 8;
  localparam int DEF_MAX_HIGH   = 60;
  localparam int DEF_RESET_CYC  = 2500;
  localparam int DEF_PIXEL_MAX  = 64;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } ws_state_t;

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchronizer for the WS2812 line plus single-cycle rise/fall
// strobes taken from the synchronized level.
module ws2812_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign din_s = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes pulse-width bits into 24-bit GRB pixels.
// Define WS2812_RX_FWD_EN to forward the stream on dout after pixel 0.
//
// state | meaning
// SYNC  | wait for RESET_CYC low cycles before trusting the line
// IDLE  | frame boundary seen, wait for first rising edge
// HIGH  | counting high cycles of a bit
// LOW   | counting low cycles after a bit, detects the reset gap
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int BIT_THRESH = DEF_BIT_THRESH,
  parameter int MIN_HIGH   = DEF_MIN_HIGH,
  parameter int MAX_HIGH   = DEF_MAX_HIGH,
  parameter int RESET_CYC  = DEF_RESET_CYC,
  parameter int PIXEL_MAX  = DEF_PIXEL_MAX
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               din,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  output logic [6:0]         pixel_idx,
  output logic               frame_done,
  output logic               err,
  output logic               dout
);

  localparam int CNT_TOP = (RESET_CYC > MAX_HIGH) ? RESET_CYC : MAX_HIGH + 1;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_T    = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_T    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_T    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [6:0]       PIX_LIM  = 7'(PIXEL_MAX);
  localparam logic [4:0]       LAST_BIT = 5'(PIXEL_W - 1);

  logic din_s, rise, fall;

  ws2812_edge_sync u_edge_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .din_s     (din_s),
    .rise      (rise),
    .fall      (fall)
  );

  ws_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             shift_en, bit_val, err_c, frame_c, clr;
  logic [4:0]       bit_cnt;
  logic [PIXEL_W-2:0] shreg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_en = 1'b0;
    bit_val  = 1'b0;
    err_c    = 1'b0;
    frame_c  = 1'b0;
    clr      = 1'b0;
    case (state)
      ST_SYNC: begin
        clr = 1'b1;
        if (din_s) begin
          cnt_n = '0;
        end else if (cnt >= RST_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_HIGH;
          cnt_n   = ONE;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          if (cnt < MIN_T) begin
            err_c   = 1'b1;
            state_n = ST_SYNC;
            cnt_n   = '0;
          end else begin
            shift_en = 1'b1;
            bit_val  = (cnt >= BIT_T);
            state_n  = ST_LOW;
            cnt_n    = ONE;
          end
        end else if (cnt >= MAX_T) begin
          // this cycle is high cycle MAX_HIGH+1
          err_c   = 1'b1;
          state_n = ST_SYNC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_n = ST_HIGH;
          cnt_n   = ONE;
        end else if (cnt >= RST_LAST) begin
          frame_c = 1'b1;
          err_c   = (bit_cnt != '0);
          clr     = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = ST_SYNC;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      pixel_data  <= '0;
      pixel_idx   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= frame_c;
      err         <= err_c;
      if (clr) begin
        bit_cnt   <= '0;
        pixel_idx <= '0;
      end else begin
        // index advances the cycle after its strobe so the strobe carries it
        if (pixel_valid && pixel_idx != PIX_LIM) begin
          pixel_idx <= pixel_idx + 7'd1;
        end
        if (shift_en) begin
          shreg <= {shreg[PIXEL_W-3:0], bit_val};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (pixel_idx < PIX_LIM) begin
              pixel_data  <= {shreg, bit_val};
              pixel_valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      end
    end
  end

`ifdef WS2812_RX_FWD_EN
  logic fwd_on;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fwd_on <= 1'b0;
      dout   <= 1'b0;
    end else begin
      if (clr) begin
        fwd_on <= 1'b0;
      end else if (shift_en && bit_cnt == LAST_BIT && pixel_idx == '0) begin
        fwd_on <= 1'b1;
      end
      dout <= fwd_on & din_s;
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: table-driven frames, boundary/glitch
// sequences and random frames against a pixel-level reference model.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        din;
  logic [23:0] pd1, pd2;
  logic        pv1, pv2, fd1, fd2, er1, er2, do1, do2;
  logic [6:0]  pi1, pi2;

  always #10 sys_clk = ~sys_clk;

  ws2812_rx dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .pixel_data(pd1), .pixel_valid(pv1), .pixel_idx(pi1),
    .frame_done(fd1), .err(er1), .dout(do1)
  );

  ws2812_rx #(.PIXEL_MAX(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .pixel_data(pd2), .pixel_valid(pv2), .pixel_idx(pi2),
    .frame_done(fd2), .err(er2), .dout(do2)
  );

  typedef struct {
    logic [23:0] data;
    int          idx;
  } pix_t;

  typedef struct {
    int          npix;
    logic [23:0] px [3];
    int          tail;
    bit          fwd;
    int          ev1, ee1, ev2, ee2;
  } vec_t;

  pix_t        got1[$], got2[$];
  logic [23:0] sent[$];
  int n_done1, n_err1, n_both1, n_done2, n_err2, n_both2, n_excl;
  int checks = 0, errors = 0;
  int dout_bad = 0;
  int cur_pix = 0;
  bit fwd_chk = 0;
  logic [2:0] dh = '0;
  vec_t tbl[5];

  always @(posedge sys_clk) dh <= {dh[1:0], din};

  always @(negedge sys_clk) begin
    if (pv1) got1.push_back('{pd1, int'(pi1)});
    if (pv2) got2.push_back('{pd2, int'(pi2)});
    if (fd1) n_done1++;
    if (er1) n_err1++;
    if (fd1 && er1) n_both1++;
    if (fd2) n_done2++;
    if (er2) n_err2++;
    if (fd2 && er2) n_both2++;
    if ((pv1 && (fd1 || er1)) || (pv2 && (fd2 || er2))) n_excl++;
`ifdef WS2812_RX_FWD_EN
    if (fwd_chk) begin
      if (cur_pix == 0 ? (do1 !== 1'b0) : (do1 !== dh[2])) dout_bad++;
    end
`else
    if (do1 !== 1'b0 || do2 !== 1'b0) dout_bad++;
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b, input int th, input int tl);
    din = 1'b1; tick(th);
    din = 1'b0; tick(tl);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i], w[i] ? 40 : 20, w[i] ? 23 : 43);
  endtask

  task automatic gap();
    din = 1'b0;
    tick(DEF_RESET_CYC + 10);
  endtask

  task automatic clear_obs();
    got1.delete(); got2.delete(); sent.delete();
    n_done1 = 0; n_err1 = 0; n_both1 = 0;
    n_done2 = 0; n_err2 = 0; n_both2 = 0;
  endtask

  // reference: pixel k of 'sent' must appear as strobe k with idx k
  task automatic compare_frame(input string tag, input int ev1, input int ee1,
                               input int ev2, input int ee2, input int edone, input int eboth);
    check($sformatf("%s.nvalid1", tag), got1.size(), ev1);
    for (int i = 0; i < got1.size() && i < ev1 && i < sent.size(); i++) begin
      check($sformatf("%s.data1_%0d", tag, i), int'(got1[i].data), int'(sent[i]));
      check($sformatf("%s.idx1_%0d", tag, i), got1[i].idx, i);
    end
    check($sformatf("%s.err1", tag), n_err1, ee1);
    check($sformatf("%s.done1", tag), n_done1, edone);
    check($sformatf("%s.both1", tag), n_both1, eboth);
    check($sformatf("%s.nvalid2", tag), got2.size(), ev2);
    for (int i = 0; i < got2.size() && i < ev2 && i < sent.size(); i++) begin
      check($sformatf("%s.data2_%0d", tag, i), int'(got2[i].data), int'(sent[i]));
      check($sformatf("%s.idx2_%0d", tag, i), got2[i].idx, i);
    end
    check($sformatf("%s.err2", tag), n_err2, ee2);
    check($sformatf("%s.done2", tag), n_done2, edone);
    check($sformatf("%s.both2", tag), n_both2, eboth);
  endtask

  task automatic set_vec(input int r, input int n, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input int tail, input bit fwd,
                         input int ev1, input int ee1, input int ev2, input int ee2);
    tbl[r].npix = n;
    tbl[r].px[0] = a; tbl[r].px[1] = b; tbl[r].px[2] = c;
    tbl[r].tail = tail; tbl[r].fwd = fwd;
    tbl[r].ev1 = ev1; tbl[r].ee1 = ee1; tbl[r].ev2 = ev2; tbl[r].ee2 = ee2;
  endtask

  initial begin
    logic [23:0] tail_w;
    logic [23:0] w;
    int          bw [4];
    int          n, nv1, nv2, th;

    tail_w = 24'hABCDEF;
    bw[0] = 8; bw[1] = 29; bw[2] = 30; bw[3] = 60;

    set_vec(0, 1, 24'hA53C0F, 24'h0, 24'h0, 0, 1'b0, 1, 0, 1, 0);
    set_vec(1, 3, 24'hFFFFFF, 24'h000000, 24'h123456, 0, 1'b0, 3, 0, 2, 1);
    set_vec(2, 0, 24'h0, 24'h0, 24'h0, 12, 1'b0, 0, 1, 0, 1);
    set_vec(3, 2, 24'hC0FFEE, 24'h5A5A5A, 24'h0, 0, 1'b1, 2, 0, 2, 0);
    set_vec(4, 3, 24'h111111, 24'h222222, 24'h333333, 12, 1'b0, 3, 1, 2, 2);

    din = 1'b0;
    sys_rst_n = 1'b0;
    n_excl = 0;
    clear_obs();
    tick(5);
    check("rst.pixel_data", int'(pd1), 0);
    check("rst.pixel_valid", int'(pv1), 0);
    check("rst.pixel_idx", int'(pi1), 0);
    check("rst.frame_done", int'(fd1), 0);
    check("rst.err", int'(er1), 0);
    check("rst.dout", int'(do1), 0);
    sys_rst_n = 1'b1;
    gap();

    for (int r = 0; r < 5; r++) begin
      clear_obs();
      fwd_chk = tbl[r].fwd;
      for (int p = 0; p < tbl[r].npix; p++) begin
        cur_pix = p;
        sent.push_back(tbl[r].px[p]);
        send_word(tbl[r].px[p]);
      end
      for (int i = 0; i < tbl[r].tail; i++) begin
        send_bit(tail_w[23-i], tail_w[23-i] ? 40 : 20, tail_w[23-i] ? 23 : 43);
      end
      gap();
      fwd_chk = 1'b0;
      cur_pix = 0;
      compare_frame($sformatf("vec%0d", r), tbl[r].ev1, tbl[r].ee1, tbl[r].ev2, tbl[r].ee2,
                    1, (tbl[r].tail != 0) ? 1 : 0);
    end

    // exact threshold widths: 8 and 29 decode 0, 30 and 60 decode 1
    clear_obs();
    w = '0;
    for (int i = 0; i < 24; i++) w[23-i] = (bw[i % 4] >= DEF_BIT_THRESH);
    sent.push_back(w);
    for (int i = 0; i < 24; i++) send_bit(1'b1, bw[i % 4], 30);
    gap();
    compare_frame("bound", 1, 0, 1, 0, 1, 0);

    // 5-cycle glitch mid-pixel, rest of pixel ignored until a reset gap
    clear_obs();
    w = 24'h5A5A5A;
    for (int i = 23; i >= 14; i--) send_bit(w[i], w[i] ? 40 : 20, w[i] ? 23 : 43);
    send_bit(1'b1, 5, 30);
    for (int i = 13; i >= 0; i--) send_bit(w[i], w[i] ? 40 : 20, w[i] ? 23 : 43);
    gap();
    compare_frame("glitch", 0, 1, 0, 1, 0, 0);
    clear_obs();
    sent.push_back(24'h0F0F0F);
    send_word(24'h0F0F0F);
    gap();
    compare_frame("glitch.fresh", 1, 0, 1, 0, 1, 0);

    // 61-cycle high pulse and 7-cycle high pulse are both errors
    clear_obs();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 40, 23);
    send_bit(1'b1, DEF_MAX_HIGH + 1, 30);
    gap();
    compare_frame("long_high", 0, 1, 0, 1, 0, 0);
    clear_obs();
    send_bit(1'b1, DEF_MIN_HIGH - 1, 30);
    gap();
    compare_frame("short_high", 0, 1, 0, 1, 0, 0);

    for (int f = 0; f < 4; f++) begin
      clear_obs();
      n = $urandom_range(1, 3);
      for (int p = 0; p < n; p++) begin
        w = 24'($urandom);
        sent.push_back(w);
        for (int i = 23; i >= 0; i--) begin
          th = w[i] ? $urandom_range(DEF_BIT_THRESH, DEF_MAX_HIGH)
                    : $urandom_range(DEF_MIN_HIGH, DEF_BIT_THRESH - 1);
          send_bit(1'b1, th, $urandom_range(3, 20));
        end
      end
      gap();
      nv1 = (n < DEF_PIXEL_MAX) ? n : DEF_PIXEL_MAX;
      nv2 = (n < 2) ? n : 2;
      compare_frame($sformatf("rand%0d", f), nv1, n - nv1, nv2, n - nv2, 1, 0);
    end

    // reset mid-frame is silent; the block resynchronizes afterwards
    clear_obs();
    for (int i = 0; i < 10; i++) send_bit(1'b1, 40, 23);
    din = 1'b1;
    tick(10);
    sys_rst_n = 1'b0;
    din = 1'b0;
    tick(3);
    check("rstmid.pixel_idx", int'(pi1), 0);
    sys_rst_n = 1'b1;
    gap();
    sent.push_back(24'h7E57ED);
    send_word(24'h7E57ED);
    gap();
    compare_frame("rstmid", 1, 0, 1, 0, 1, 0);

    check("exclusive_strobes", n_excl, 0);
    check("dout_behaviour", dout_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
